// File: rtl/ctrl_tx_arbiter_if.sv
// Stream bundle between the four control-packet sources, the arbiter and the UDP TX path.
// The arbiter attaches through the slave modport; the traffic side uses the master modport.
interface ctrl_tx_arbiter_if;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tlast;
    logic [3:0]   s_tready;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tkeep;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;

    modport slave (
        input  s_tdata, s_tkeep, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
    );

    modport master (
        output s_tdata, s_tkeep, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
    );
endinterface

// File: rtl/ctrl_tx_arbiter.sv
// Four-source packet-atomic control arbiter with oversize truncation and drop.
// CTRL_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority src0 > src3.
module ctrl_tx_arbiter #(
    parameter int MAX_BEATS = 16
) (
    input  logic                  core_clk,
    input  logic                  core_rst_n,
    ctrl_tx_arbiter_if.slave      bus,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic                  err_oversize,
    output logic [31:0]           pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [7:0] LAST_BEAT_IDX = 8'(MAX_BEATS - 1);

    state_t      state_r, state_next_s;
    logic [1:0]  grant_r, grant_next_s, winner_s;
    logic [7:0]  beat_r;
    logic [31:0] pkt_cnt_r;
    logic        err_r, busy_r;
    logic [63:0] lane_data_s;
    logic [7:0]  lane_keep_s;
    logic        lane_valid_s, lane_last_s;
    logic        at_limit_s, xfer_s, over_s;

    function automatic logic [1:0] pick_fixed(input logic [3:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Search starts one past the previous winner; the last assignment is the nearest requester.
    function automatic logic [1:0] pick_rr(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx, cand;
        idx = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
        return idx;
    endfunction

`ifdef CTRL_ARB_RR_EN
    logic [1:0] last_grant_r;

    assign winner_s = pick_rr(bus.s_tvalid, last_grant_r);

    // Remember the most recent winner so the next search starts after it.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            last_grant_r <= 2'd3;
        end else if (state_r == IDLE && (|bus.s_tvalid)) begin
            last_grant_r <= winner_s;
        end
    end
`else
    assign winner_s = pick_fixed(bus.s_tvalid);
`endif

    assign lane_data_s  = bus.s_tdata[{grant_r, 6'd0} +: 64];
    assign lane_keep_s  = bus.s_tkeep[{grant_r, 3'd0} +: 8];
    assign lane_valid_s = bus.s_tvalid[grant_r];
    assign lane_last_s  = bus.s_tlast[grant_r];
    assign at_limit_s   = (beat_r == LAST_BEAT_IDX);

    // Next-state decode plus the combinational forwarding path of the granted lane.
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_r;
        bus.m_tdata  = 64'd0;
        bus.m_tkeep  = 8'd0;
        bus.m_tvalid = 1'b0;
        bus.m_tlast  = 1'b0;
        bus.s_tready = 4'd0;
        xfer_s       = 1'b0;
        over_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (|bus.s_tvalid) begin
                    state_next_s = FWD;
                    grant_next_s = winner_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FWD: begin
                bus.m_tdata  = lane_data_s;
                bus.m_tkeep  = lane_keep_s;
                bus.m_tvalid = lane_valid_s;
                bus.m_tlast  = lane_last_s | at_limit_s;
                bus.s_tready = bus.m_tready ? (4'b0001 << grant_r) : 4'b0000;
                xfer_s       = lane_valid_s & bus.m_tready;
                over_s       = xfer_s & at_limit_s & ~lane_last_s;
                if (xfer_s && lane_last_s) begin
                    state_next_s = IDLE;
                end else if (over_s) begin
                    state_next_s = DROP;
                end else begin
                    state_next_s = FWD;
                end
            end
            DROP: begin
                bus.s_tready = 4'b0001 << grant_r;
                if (lane_valid_s && lane_last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DROP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, grant, beat counter, packet counter and status flags.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_r   <= IDLE;
            grant_r   <= 2'd0;
            beat_r    <= 8'd0;
            pkt_cnt_r <= 32'd0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            grant_r <= grant_next_s;
            err_r   <= over_s;
            busy_r  <= (state_next_s != IDLE);
            if (state_r == IDLE) begin
                beat_r <= 8'd0;
            end else if (xfer_s) begin
                beat_r <= beat_r + 8'd1;
            end
            if (xfer_s && bus.m_tlast) begin
                pkt_cnt_r <= pkt_cnt_r + 32'd1;
            end
        end
    end

    assign grant_id     = grant_r;
    assign busy         = busy_r;
    assign err_oversize = err_r;
    assign pkt_cnt      = pkt_cnt_r;

endmodule
